// File: rtl/addr_map_pkg.sv
// Default address map of the RISC core memory bus, shared by the decoder and its users.
// Region windows are inclusive [base, limit]; region 0 sits in the LSBs of the packed vectors.
package addr_map_pkg;

    localparam int MAP_ADDR_W = 32;
    localparam int MAP_NREG   = 4;

    localparam int REG_DATA = 0;
    localparam int REG_PROG = 1;
    localparam int REG_IO   = 2;
    localparam int REG_EXT  = 3;

    localparam logic [MAP_ADDR_W-1:0] DATA_BASE  = 32'h0000_0000;
    localparam logic [MAP_ADDR_W-1:0] DATA_LIMIT = 32'h0000_040F;
    localparam logic [MAP_ADDR_W-1:0] PROG_BASE  = 32'h0000_0410;
    localparam logic [MAP_ADDR_W-1:0] PROG_LIMIT = 32'h0000_080F;
    localparam logic [MAP_ADDR_W-1:0] IO_BASE    = 32'h0000_0810;
    localparam logic [MAP_ADDR_W-1:0] IO_LIMIT   = 32'h0000_0FFF;
    localparam logic [MAP_ADDR_W-1:0] EXT_BASE   = 32'h0000_1000;
    localparam logic [MAP_ADDR_W-1:0] EXT_LIMIT  = 32'h0000_1FFF;

    localparam logic [MAP_NREG*MAP_ADDR_W-1:0] DEF_REG_BASE =
        {EXT_BASE, IO_BASE, PROG_BASE, DATA_BASE};
    localparam logic [MAP_NREG*MAP_ADDR_W-1:0] DEF_REG_LIMIT =
        {EXT_LIMIT, IO_LIMIT, PROG_LIMIT, DATA_LIMIT};

endpackage

// File: rtl/addr_region_match.sv
// Single-window comparator: hit when base <= addr <= limit (unsigned), plus the window offset.
// A window with base > limit can never hit, which is how a region is disabled.
module addr_region_match #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] limit,
    output logic              hit,
    output logic [ADDR_W-1:0] offset
);

    assign hit    = (addr >= base) && (addr <= limit);
    // Only meaningful when hit; the top level ignores it otherwise.
    assign offset = addr - base;

endmodule

// File: rtl/addr_decode_mr.sv
// Multi-region pipelined address decoder: lowest-index window wins, result registered one
// cycle after accept, with sticky first-fault address and saturating fault counter.
module addr_decode_mr
    import addr_map_pkg::*;
#(
    parameter int                        ADDR_W    = 32,
    parameter int                        NREG      = 4,
    parameter logic [NREG*ADDR_W-1:0]    REG_BASE  = DEF_REG_BASE,
    parameter logic [NREG*ADDR_W-1:0]    REG_LIMIT = DEF_REG_LIMIT,
    parameter int                        CNT_W     = 8,
    localparam int                       RGN_W     = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [NREG-1:0]   rsp_cs,
    output logic [RGN_W-1:0]  rsp_region,
    output logic [ADDR_W-1:0] rsp_offset,
    output logic              rsp_fault,
    input  logic              fault_clr,
    output logic              fault_sticky,
    output logic [ADDR_W-1:0] fault_addr,
    output logic [CNT_W-1:0]  fault_cnt
);

    logic [NREG-1:0]   hit;
    logic [ADDR_W-1:0] off [NREG];

    for (genvar g = 0; g < NREG; g++) begin : g_match
        addr_region_match #(.ADDR_W(ADDR_W)) u_match (
            .addr   (req_addr),
            .base   (REG_BASE[g*ADDR_W +: ADDR_W]),
            .limit  (REG_LIMIT[g*ADDR_W +: ADDR_W]),
            .hit    (hit[g]),
            .offset (off[g])
        );
    end

    logic              win_hit;
    logic [RGN_W-1:0]  win_idx;
    logic [NREG-1:0]   win_cs;
    logic [ADDR_W-1:0] win_off;

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        win_hit = 1'b0;
        win_idx = '0;
        win_cs  = '0;
        win_off = '0;
        for (int r = NREG - 1; r >= 0; r--) begin
            if (hit[r]) begin
                win_hit    = 1'b1;
                win_idx    = RGN_W'(r);
                win_cs     = '0;
                win_cs[r]  = 1'b1;
                win_off    = off[r];
            end
        end
    end

    // Handshake: a transfer happens on a rising edge where valid && ready. The decoder
    // accepts whenever its output slot is empty or being drained this cycle, so req_ready
    // depends only on the output side and never on req_*.
    logic accept;
    logic fault_acc;

    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign fault_acc = accept && !win_hit;

    logic              valid_q, valid_d;
    logic [NREG-1:0]   cs_q, cs_d;
    logic [RGN_W-1:0]  region_q, region_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic              fault_q, fault_d;
    logic              sticky_q, sticky_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        valid_d  = valid_q;
        cs_d     = cs_q;
        region_d = region_q;
        offset_d = offset_q;
        fault_d  = fault_q;
        sticky_d = sticky_q;
        faddr_d  = faddr_q;
        cnt_d    = cnt_q;

        if (accept) begin
            valid_d  = 1'b1;
            cs_d     = win_cs;
            region_d = win_idx;
            offset_d = win_off;
            fault_d  = !win_hit;
        end else if (rsp_ready) begin
            valid_d  = 1'b0;
        end

        if (fault_clr) begin
            sticky_d = 1'b0;
        end
        // A fault arriving with a clear counts as the first fault of the new epoch.
        if (fault_acc) begin
            sticky_d = 1'b1;
            if (!sticky_q || fault_clr) begin
                faddr_d = req_addr;
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            cs_q     <= '0;
            region_q <= '0;
            offset_q <= '0;
            fault_q  <= 1'b0;
            sticky_q <= 1'b0;
            faddr_q  <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            cs_q     <= cs_d;
            region_q <= region_d;
            offset_q <= offset_d;
            fault_q  <= fault_d;
            sticky_q <= sticky_d;
            faddr_q  <= faddr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rsp_valid    = valid_q;
    assign rsp_cs       = cs_q;
    assign rsp_region   = region_q;
    assign rsp_offset   = offset_q;
    assign rsp_fault    = fault_q;
    assign fault_sticky = sticky_q;
    assign fault_addr   = faddr_q;
    assign fault_cnt    = cnt_q;

endmodule
